// File: rtl/rcc_pkg.sv
// Shared types for the RCC divider-ratio change sequencer.
package rcc_pkg;

    localparam int unsigned RatioWidth = 8;

    typedef logic [RatioWidth-1:0] ratio_t;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StDrain,
        StGate,
        StLoad,
        StSettle,
        StRelease
    } rcc_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rcc_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rcc_rr_arb #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic        found;
    int unsigned k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IdxW'(k);
            end
        end
    end

endmodule

// File: rtl/rcc_div_seq.sv
// Sequences divider-ratio changes per clock domain: drain, gate, load, settle, release.
module rcc_div_seq
    import rcc_pkg::*;
#(
    parameter int unsigned NUM_DOM       = 3,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned RESET_RATIO   = 2,
    parameter int unsigned GATE_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [NUM_DOM-1:0]         req,
    input  logic [NUM_DOM*WIDTH-1:0]   new_ratio,
    input  logic [NUM_DOM-1:0]         quiet,
    output logic [NUM_DOM*WIDTH-1:0]   div_ratio,
    output logic [NUM_DOM-1:0]         clk_en,
    output logic [NUM_DOM-1:0]         ack,
    output logic [NUM_DOM-1:0]         err,
    output logic                       busy
);

    localparam int unsigned IdxW   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int unsigned CntMax = max3(GATE_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT);
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [WIDTH-1:0] ResetR = WIDTH'(RESET_RATIO);

    rcc_state_e                 state_q, state_d;
    logic [IdxW-1:0]            ptr_q, ptr_d;
    logic [NUM_DOM-1:0]         snap_q, snap_d;
    logic [IdxW-1:0]            g_q, g_d;
    logic [NUM_DOM-1:0]         gnt_q, gnt_d;
    logic [WIDTH-1:0]           lat_q, lat_d;
    logic                       fail_q, fail_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [NUM_DOM*WIDTH-1:0]   ratio_q, ratio_d;
    logic [NUM_DOM-1:0]         clk_en_q, clk_en_d;
    logic [NUM_DOM-1:0]         ack_q, ack_d;
    logic [NUM_DOM-1:0]         err_q, err_d;
    logic                       busy_q, busy_d;

    logic [NUM_DOM-1:0]         arb_gnt;
    logic [IdxW-1:0]            arb_idx;
    logic [WIDTH-1:0]           arb_ratio;
    logic [WIDTH-1:0]           cur_ratio;

    // Arbitrate on the request snapshot taken in IDLE so mid-sequence req changes are ignored.
    rcc_rr_arb #(
        .N    (NUM_DOM),
        .IdxW (IdxW)
    ) u_arb (
        .req_i (snap_q),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign arb_ratio = new_ratio[arb_idx*WIDTH +: WIDTH];
    assign cur_ratio = ratio_q[arb_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        snap_d  = snap_q;
        g_d     = g_q;
        gnt_d   = gnt_q;
        lat_d   = lat_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    snap_d  = req;
                    state_d = StArb;
                end
            end
            StArb: begin
                g_d    = arb_idx;
                gnt_d  = arb_gnt;
                lat_d  = arb_ratio;
                fail_d = 1'b0;
                if (arb_ratio == '0) begin
                    fail_d  = 1'b1;
                    state_d = StRelease;
                end else if (arb_ratio == cur_ratio) begin
                    state_d = StRelease;
                end else begin
                    cnt_d   = CntW'(DRAIN_TIMEOUT - 1);
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (quiet[g_q]) begin
                    cnt_d   = CntW'(GATE_CYCLES - 1);
                    state_d = StGate;
                end else if (cnt_q == '0) begin
                    fail_d  = 1'b1;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGate: begin
                if (cnt_q == '0) begin
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StLoad: begin
                ratio_d[g_q*WIDTH +: WIDTH] = lat_q;
                cnt_d   = CntW'(SETTLE_CYCLES - 1);
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRelease: begin
                ptr_d   = (g_q == IdxW'(NUM_DOM - 1)) ? '0 : g_q + IdxW'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        clk_en_d = '1;
        ack_d    = '0;
        err_d    = '0;
        if (state_d == StGate || state_d == StLoad || state_d == StSettle) begin
            clk_en_d = ~gnt_d;
        end
        if (state_d == StRelease) begin
            ack_d = gnt_d;
            if (fail_d) begin
                err_d = gnt_d;
            end
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            snap_q   <= '0;
            g_q      <= '0;
            gnt_q    <= '0;
            lat_q    <= '0;
            fail_q   <= 1'b0;
            cnt_q    <= '0;
            ratio_q  <= {NUM_DOM{ResetR}};
            clk_en_q <= '1;
            ack_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            snap_q   <= snap_d;
            g_q      <= g_d;
            gnt_q    <= gnt_d;
            lat_q    <= lat_d;
            fail_q   <= fail_d;
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            clk_en_q <= clk_en_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign div_ratio = ratio_q;
    assign clk_en    = clk_en_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: doc/rcc_div_seq.md
RCC_DIV_SEQ -- requirements
Module: rcc_div_seq

Interface
REQ-001 SHALL have parameter NUM_DOM, default 3, number of divided clock domains sequenced (index 0 PCLK, 1 TIMCLK, 2 WDOGCLK).
REQ-002 SHALL have parameter WIDTH, default 8, divider ratio width.
REQ-003 SHALL have parameter RESET_RATIO, default 2, ratio driven on every domain after reset.
REQ-004 SHALL have parameter GATE_CYCLES, default 2, cycles clk_en is held low before load.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 4, cycles held after load before clk_en is released.
REQ-006 SHALL have parameter DRAIN_TIMEOUT, default 64, maximum cycles waited for quiet.
REQ-007 Ports: HCLK input 1, sole clock; HRESETn input 1, reset, asynchronous active-low.
REQ-008 Ports: req input NUM_DOM, per-domain ratio-change request, level, held until ack.
REQ-009 Ports: new_ratio input NUM_DOM*WIDTH, requested ratio per domain, slice d = bits [d*WIDTH +: WIDTH].
REQ-010 Ports: quiet input NUM_DOM, domain has no transfer in flight.
REQ-011 Ports: div_ratio output NUM_DOM*WIDTH, ratio driven to each domain divider.
REQ-012 Ports: clk_en output NUM_DOM, per-domain clock gate enable.
REQ-013 Ports: ack output NUM_DOM, one-cycle completion pulse; err output NUM_DOM, one-cycle pulse coincident with ack on rejection/abort; busy output 1, sequencer not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ARB, DRAIN, GATE, LOAD, SETTLE, RELEASE.
REQ-015 IDLE -> ARB when any req bit is high; otherwise remain.
REQ-016 ARB (1 cycle): round-robin grant starting at pointer; latch granted index g and new_ratio slice g.
REQ-017 ARB: latched ratio 0 -> RELEASE with err[g]; latched ratio equal to div_ratio slice g -> RELEASE without err, no gating; else -> DRAIN.
REQ-018 DRAIN: -> GATE on first cycle quiet[g]=1 (minimum 1 cycle); after DRAIN_TIMEOUT cycles without quiet -> RELEASE with err[g], ratio unchanged.
REQ-019 GATE: clk_en[g]=0 for exactly GATE_CYCLES cycles, then LOAD.
REQ-020 LOAD (1 cycle): div_ratio slice g takes latched ratio at end of cycle; clk_en[g] stays 0.
REQ-021 SETTLE: clk_en[g]=0 for exactly SETTLE_CYCLES cycles, then RELEASE.
REQ-022 RELEASE (1 cycle): clk_en[g]=1, ack[g]=1, err[g] per REQ-017/018; pointer <= (g+1) mod NUM_DOM; -> IDLE.
REQ-023 Non-granted domains' clk_en and div_ratio SHALL never change during a sequence.
REQ-024 At most one ack bit high in any cycle; one sequence in progress at a time.
REQ-025 req changes during a sequence SHALL be ignored until IDLE; req still high in IDLE after its ack starts a new sequence.
REQ-026 Simultaneous requests SHALL each complete in round-robin order; no domain waits more than NUM_DOM-1 sequences.
REQ-027 Nominal latency (quiet=1, defaults): ack in 10th cycle after edge sampling req in IDLE.
REQ-028 busy=1 in every state other than IDLE; all outputs registered.

Reset
REQ-029 On HRESETn low, immediately: state IDLE, div_ratio all RESET_RATIO, clk_en all 1, ack 0, err 0, busy 0, pointer 0, counters 0.
REQ-030 Reset mid-sequence SHALL abort without ack; gated domain's clk_en returns to 1 and its ratio to RESET_RATIO.

Structure
REQ-031 State enum and ratio width typedef SHALL reside in shared package rcc_pkg.
REQ-032 Round-robin arbiter SHALL be sub-module rcc_rr_arb (req, pointer in, one-hot grant, index out, combinational).
REQ-033 GATE, SETTLE and DRAIN SHALL share one down-counter sized for max(GATE_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT).

Verification
REQ-034 Reset, then req[0]=1, new_ratio0=4, quiet=all 1 -> clk_en[0] low 7 cycles, div_ratio0=4, ack[0] in 10th cycle, err 0.
REQ-035 req=3'b111 same cycle, ratios 3,5,7 -> acks in order 0,1,2, one per sequence, ratios applied only to own domain.
REQ-036 req[1]=1, new_ratio1=0 -> ack[1]+err[1] in 2nd cycle, clk_en[1] never low, div_ratio1 stays 2.
REQ-037 req[2]=1, new_ratio2=2 (equal to current) -> ack[2] in 2nd cycle, err 0, no gating.
REQ-038 req[0]=1, ratio 6, quiet[0]=0 held -> after 64 DRAIN cycles ack[0]+err[0], div_ratio0 stays 2, clk_en[0] never low.
REQ-039 Assert HRESETn low during SETTLE of domain 1 -> clk_en all 1, div_ratio all 2, no ack, busy 0 immediately.
